// File: rtl/gear_shift_ctrl.sv
// gear_shift_ctrl: sequences manual/auto gear shifts through a timed clutch-open phase,
// refusing unsafe requests and holding one button request that arrives mid-shift.
module gear_shift_ctrl #(
  parameter int SHIFT_TICKS   = 3,
  parameter int UPSHIFT_RPM   = 6000,
  parameter int DOWNSHIFT_RPM = 1500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_10hz,
  input  logic       shift_up,
  input  logic       shift_down,
  input  logic       auto_mode,
  input  logic [8:0] speed_kmh,
  input  logic [13:0] rpm,
  output logic [2:0] gear,
  output logic [2:0] gear_target,
  output logic       shifting,
  output logic       shift_denied
);
  typedef enum logic [1:0] {IDLE, CLUTCH, ENGAGE} state_t;
  localparam logic [13:0] UP_RPM = 14'(UPSHIFT_RPM);
  localparam logic [13:0] DN_RPM = 14'(DOWNSHIFT_RPM);
  localparam logic [3:0]  LAST   = 4'(SHIFT_TICKS - 1);
  state_t     state;
  logic [3:0] cnt;
  logic       pend_v, pend_up;
  logic       both, btn, auto_up, auto_req, req, up, ok, over;
  logic [2:0] nxt;
  function automatic logic [8:0] max_speed(input logic [2:0] g);
    case (g)
      3'd1:    return 9'd30;
      3'd2:    return 9'd70;
      3'd3:    return 9'd130;
      3'd4:    return 9'd200;
      3'd5:    return 9'd300;
      3'd6:    return 9'd400;
      default: return 9'd0;
    endcase
  endfunction
  always_comb begin
    both     = shift_up & shift_down;
    btn      = shift_up ^ shift_down;
    auto_up  = rpm >= UP_RPM && gear < 3'd6;
    auto_req = auto_mode && tick_10hz && gear != 3'd0 && (auto_up || (rpm <= DN_RPM && gear > 3'd1));
    req      = pend_v || btn || (auto_req && !both);
    up       = pend_v ? pend_up : btn ? shift_up : auto_up;
    nxt      = up ? gear + 3'd1 : gear - 3'd1;
    ok       = up ? (gear != 3'd6 && !(gear == 3'd0 && speed_kmh > 9'd30))
                  : (gear > 3'd1 && speed_kmh <= max_speed(gear - 3'd1));
    over     = speed_kmh > max_speed(gear_target);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      pend_v       <= 1'b0;
      pend_up      <= 1'b0;
      gear         <= '0;
      gear_target  <= '0;
      shifting     <= 1'b0;
      shift_denied <= 1'b0;
    end else begin
      shift_denied <= 1'b0;
      case (state)
        IDLE: begin
          if (req && ok) begin
            gear_target <= nxt;
            gear        <= '0;
            shifting    <= 1'b1;
            cnt         <= '0;
            state       <= CLUTCH;
          end
          if ((req && !ok) || both) shift_denied <= 1'b1;
          // the slot is consumed now, so a button in this same clk can refill it
          if (pend_v) begin
            pend_v  <= btn;
            pend_up <= shift_up;
          end
        end
        CLUTCH: if (tick_10hz) begin
          cnt <= cnt + 4'd1;
          if (cnt == LAST) state <= ENGAGE;
        end
        ENGAGE: begin
          if (over) begin
            gear_target  <= '0;
            shift_denied <= 1'b1;
          end else gear <= gear_target;
          shifting <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (state != IDLE) begin
        if (both || (btn && pend_v)) shift_denied <= 1'b1;
        else if (btn) begin
          pend_v  <= 1'b1;
          pend_up <= shift_up;
        end
      end
    end
  end
endmodule

// File: tb/tb_gear_shift_ctrl.sv
// tb_gear_shift_ctrl: per-clock directed vectors with hand-computed outputs,
// plus hand sequences for climbing to 6th and an asynchronous reset mid-shift.
module tb_gear_shift_ctrl;
  logic        clk = 0, rst = 1, tick_10hz = 0, shift_up = 0, shift_down = 0, auto_mode = 0;
  logic [8:0]  speed_kmh = 0;
  logic [13:0] rpm = 0;
  logic [2:0]  gear, gear_target;
  logic        shifting, shift_denied;
  int          errors = 0, checks = 0, row = 0;
  typedef struct {
    logic u, d, a, t;
    logic [8:0] spd;
    logic [13:0] r;
    logic [2:0] eg, et;
    logic es, ed;
  } vec_t;
  vec_t tab[$];
  gear_shift_ctrl dut (
    .clk(clk), .rst(rst), .tick_10hz(tick_10hz), .shift_up(shift_up), .shift_down(shift_down),
    .auto_mode(auto_mode), .speed_kmh(speed_kmh), .rpm(rpm), .gear(gear),
    .gear_target(gear_target), .shifting(shifting), .shift_denied(shift_denied)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(input logic u, d, a, t, input int spd, r, eg, et, input logic es, ed);
    vec_t v;
    v = '{u:u, d:d, a:a, t:t, spd:9'(spd), r:14'(r), eg:3'(eg), et:3'(et), es:es, ed:ed};
    return v;
  endfunction
  task automatic chk(input string n, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL row %0d %s: got %0d expected %0d", row, n, got, exp);
    end
  endtask
  task automatic outs(input int eg, et, es, ed);
    chk("gear", gear, eg);
    chk("gear_target", gear_target, et);
    chk("shifting", shifting, es);
    chk("shift_denied", shift_denied, ed);
  endtask
  task automatic step(input vec_t v);
    shift_up = v.u; shift_down = v.d; auto_mode = v.a; tick_10hz = v.t;
    speed_kmh = v.spd; rpm = v.r;
    @(posedge clk);
    #1;
    outs(v.eg, v.et, v.es, v.ed);
    row++;
  endtask
  initial begin
    // manual 0->1, three ticks of clutch, one ENGAGE clk
    tab.push_back(mk(1,0,0,0,  0,   0, 0,1,1,0));
    tab.push_back(mk(0,0,0,1,  0,   0, 0,1,1,0));
    tab.push_back(mk(0,0,0,0,  0,   0, 0,1,1,0));
    tab.push_back(mk(0,0,0,1,  0,   0, 0,1,1,0));
    tab.push_back(mk(0,0,0,1,  0,   0, 0,1,1,0));
    tab.push_back(mk(0,0,0,0,  0,   0, 1,1,0,0));
    // 1->2 with a queued up, third pulse refused
    tab.push_back(mk(1,0,0,0,  0,   0, 0,2,1,0));
    tab.push_back(mk(1,0,0,0,  0,   0, 0,2,1,0));
    tab.push_back(mk(1,0,0,0,  0,   0, 0,2,1,1));
    tab.push_back(mk(0,0,0,1,  0,   0, 0,2,1,0));
    tab.push_back(mk(0,0,0,1,  0,   0, 0,2,1,0));
    tab.push_back(mk(0,0,0,1,  0,   0, 0,2,1,0));
    tab.push_back(mk(0,0,0,0,  0,   0, 2,2,0,0));
    tab.push_back(mk(0,0,0,0,  0,   0, 0,3,1,0));
    tab.push_back(mk(0,0,0,1,  0,   0, 0,3,1,0));
    tab.push_back(mk(0,0,0,1,  0,   0, 0,3,1,0));
    tab.push_back(mk(0,0,0,1,  0,   0, 0,3,1,0));
    tab.push_back(mk(0,0,0,0,  0,   0, 3,3,0,0));
    // downshift speed limit: 100 > 70 refused, 60 accepted
    tab.push_back(mk(0,1,0,0,100,   0, 3,3,0,1));
    tab.push_back(mk(0,0,0,0,100,   0, 3,3,0,0));
    tab.push_back(mk(0,1,0,0, 60,   0, 0,2,1,0));
    tab.push_back(mk(0,0,0,1, 60,   0, 0,2,1,0));
    tab.push_back(mk(0,0,0,1, 60,   0, 0,2,1,0));
    tab.push_back(mk(0,0,0,1, 60,   0, 0,2,1,0));
    tab.push_back(mk(0,0,0,0, 60,   0, 2,2,0,0));
    // auto up at 6200 rpm, auto down at 1400 rpm
    tab.push_back(mk(0,0,1,1, 60,6200, 0,3,1,0));
    tab.push_back(mk(0,0,0,1, 60,3000, 0,3,1,0));
    tab.push_back(mk(0,0,0,1, 60,3000, 0,3,1,0));
    tab.push_back(mk(0,0,0,1, 60,3000, 0,3,1,0));
    tab.push_back(mk(0,0,0,0, 60,3000, 3,3,0,0));
    tab.push_back(mk(0,0,1,1, 50,1400, 0,2,1,0));
    tab.push_back(mk(0,0,0,1, 50,3000, 0,2,1,0));
    tab.push_back(mk(0,0,0,1, 50,3000, 0,2,1,0));
    tab.push_back(mk(0,0,0,1, 50,3000, 0,2,1,0));
    tab.push_back(mk(0,0,0,0, 50,3000, 2,2,0,0));
    // auto without tick does nothing; exactly 6000 rpm upshifts
    tab.push_back(mk(0,0,1,0, 50,6200, 2,2,0,0));
    tab.push_back(mk(0,0,1,1, 50,6000, 0,3,1,0));
    tab.push_back(mk(0,0,0,1, 50,3000, 0,3,1,0));
    tab.push_back(mk(0,0,0,1, 50,3000, 0,3,1,0));
    tab.push_back(mk(0,0,0,1, 50,3000, 0,3,1,0));
    tab.push_back(mk(0,0,0,0, 50,3000, 3,3,0,0));
    // downshift becomes illegal while coasting: ENGAGE aborts to neutral
    tab.push_back(mk(0,1,0,0, 60,   0, 0,2,1,0));
    tab.push_back(mk(0,0,0,1, 80,   0, 0,2,1,0));
    tab.push_back(mk(0,0,0,1, 80,   0, 0,2,1,0));
    tab.push_back(mk(0,0,0,1, 80,   0, 0,2,1,0));
    tab.push_back(mk(0,0,0,0, 80,   0, 0,0,0,1));
    // both buttons refused; 0->1 limit at 31 vs 30
    tab.push_back(mk(1,1,0,0,  0,   0, 0,0,0,1));
    tab.push_back(mk(0,0,0,0,  0,   0, 0,0,0,0));
    tab.push_back(mk(1,0,0,0, 31,   0, 0,0,0,1));
    tab.push_back(mk(1,0,0,0, 30,   0, 0,1,1,0));
    tab.push_back(mk(0,0,0,1, 30,   0, 0,1,1,0));
    tab.push_back(mk(0,0,0,1, 30,   0, 0,1,1,0));
    tab.push_back(mk(0,0,0,1, 30,   0, 0,1,1,0));
    tab.push_back(mk(0,0,0,0, 30,   0, 1,1,0,0));
    // down from 1 refused; auto never downshifts below 1
    tab.push_back(mk(0,1,0,0,  0,   0, 1,1,0,1));
    tab.push_back(mk(0,0,1,1,  0,1000, 1,1,0,0));
    repeat (2) @(posedge clk);
    #1;
    outs(0, 0, 0, 0);
    rst = 0;
    foreach (tab[i]) step(tab[i]);
    // climb from 1 to 6, then up at 6 is refused
    for (int g = 1; g < 6; g++) begin
      step(mk(1,0,0,0, 0,0, 0,g+1,1,0));
      repeat (3) step(mk(0,0,0,1, 0,0, 0,g+1,1,0));
      step(mk(0,0,0,0, 0,0, g+1,g+1,0,0));
    end
    step(mk(1,0,0,0, 0,0, 6,6,0,1));
    step(mk(0,0,0,0, 0,0, 6,6,0,0));
    // queue an up during clutch, then reset asynchronously before ENGAGE
    step(mk(0,1,0,0, 0,0, 0,5,1,0));
    step(mk(1,0,0,1, 0,0, 0,5,1,0));
    step(mk(0,0,0,1, 0,0, 0,5,1,0));
    #2 rst = 1;
    #1 outs(0, 0, 0, 0);
    @(negedge clk) rst = 0;
    step(mk(0,0,0,0, 0,0, 0,0,0,0));
    step(mk(1,0,0,0, 0,0, 0,1,1,0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
